pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit shifter used by the ALU/datapath.
- Generalised in data width and pipeline depth; adds a rotate-right mode, a valid/ready handshake with backpressure, and a sideband tag carried alongside each operation.
- Sits between the issue logic and writeback for shift instructions, or in any multi-cycle datapath that needs a registered shifter.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of 2, >= 8.
- STAGES, 2, register stages; 1 <= STAGES <= SHAMT_W.
- TAG_WIDTH, 4, sideband tag width; >= 1.
- Derived: SHAMT_W = clog2(DATA_WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  shifter can accept a request this cycle.
- in_a  input  DATA_WIDTH  operand.
- in_b  input  SHAMT_W  shift amount; only these bits are used.
- in_op  input  2  00 SLL, 10 SRL, 11 SRA, 01 ROR (optional; see below).
- in_tag  input  TAG_WIDTH  returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  DATA_WIDTH  shifted value.
- out_tag  output  TAG_WIDTH  tag of out_result.

Behaviour:
- Reset, asynchronous: all stage valid bits = 0, so in_ready = 1 and out_valid = 0. out_result = 0 and out_tag = 0.
- Reset mid-operation: all in-flight operations are discarded. No result is emitted for them after reset deasserts.
- Structure: SHAMT_W log-levels; level k shifts by 2^k when b[k] = 1. Level k lives in stage floor(k*STAGES/SHAMT_W). Each stage ends in a register holding valid, data, remaining b, op, tag and the fill bit.
- Fill bit: captured at entry. SLL/SRL use 0; SRA uses a[DATA_WIDTH-1]. ROR wraps the bits shifted out back in at the MSB.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no backpressure.
- Throughput: one operation per cycle while out_ready = 1.
- Outputs: out_* come from the last stage register. No combinational path from in_* to out_*.
- Flow control, per stage: stage i advances when it is empty, or when stage i+1 advances (or out_ready = 1 for the last stage).
  - in_ready = stage0 empty or stage0 advances.
  - This is a combinational ready chain; no skid buffer.
- Handshake rules:
  - out_result, out_tag and out_valid stay stable while out_valid = 1 and out_ready = 0.
  - Accepted operations are never dropped or reordered.
  - An op with in_valid = 0 is not accepted. Inputs are don't-care when in_valid = 0.
- Simultaneous events: with the pipe full, out_ready = 1 and in_valid = 1 in the same cycle, the last stage retires and a new op enters stage0 on that edge.
- Shift amount boundaries:
  - b = 0 returns a unchanged for every op.
  - b = DATA_WIDTH-1 with SRA of a negative value gives all ones.
- Undefined op (01 with the macro off): out_result = 0. Tag and handshake behave normally.

Optional Feature:
- Macro: PIPELINED_SHIFTER_ROTATE_EN.
- Defined: op 01 performs rotate-right by in_b.
- Undefined: the rotate datapath is not built, and op 01 yields 0.

Test Plan:
- STAGES=2, W=32, out_ready=1. SLL a=0x00000001 b=31 tag=3 -> out_valid exactly 2 cycles later, result 0x80000000, tag 3.
- SRL a=0xF0000000 b=4 -> 0x0F000000. SRA same inputs -> 0xFF000000. SRA a=0x80000000 b=31 -> 0xFFFFFFFF. b=0 for each op -> a unchanged.
- Back-to-back: 8 ops, one per cycle, tags 0..7 -> 8 consecutive out_valid cycles, in order, with correct results.
- Backpressure: hold out_ready=0 and offer 4 ops.
  - Only 2 ops are accepted, and in_ready=0 after that.
  - out_result stays stable while out_ready=0.
  - After out_ready rises, all 4 ops emerge in order with none lost.
- Rotate: with the macro defined, ROR a=0x00000001 b=1 -> 0x80000000, and a=0x12345678 b=8 -> 0x78123456. With the macro undefined, op 01 -> 0.
- Reset: assert rst with 2 ops in flight -> out_valid=0 and in_ready=1 immediately (asynchronously). No stale result appears after reset is released.

Source files
------------

// File: rtl/pipelined_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_shifter
//
// Registered barrel shifter with a valid/ready handshake on both sides.
// The shift is split into SHAMT_W log-levels (level k shifts by 2^k when
// b[k] is set). The levels are spread across STAGES register stages.
// Each stage register carries valid, data, shift amount, op, tag and the
// fill bit, so the result leaves the last stage together with its tag.
//
// Ops: 00 SLL, 10 SRL, 11 SRA, 01 ROR.
// Optional feature macro: PIPELINED_SHIFTER_ROTATE_EN
//   defined   -> op 01 rotates right by in_b
//   undefined -> no rotate datapath is built; op 01 returns 0
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     request valid
//   in_ready     shifter can take a request this cycle
//   in_a         operand
//   in_b         shift amount (SHAMT_W bits)
//   in_op        operation select
//   in_tag       sideband tag returned with the result
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_result   shifted value
//   out_tag      tag belonging to out_result
// ---------------------------------------------------------------------------
module pipelined_shifter #(
    parameter int  DATA_WIDTH = 32,
    parameter int  STAGES     = 2,
    parameter int  TAG_WIDTH  = 4,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [SHAMT_W-1:0]    in_b,
    input  logic [1:0]            in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic                  valid_q [STAGES];
    logic                  valid_d [STAGES];
    logic [DATA_WIDTH-1:0] data_q  [STAGES];
    logic [DATA_WIDTH-1:0] data_d  [STAGES];
    logic [SHAMT_W-1:0]    b_q     [STAGES];
    logic [SHAMT_W-1:0]    b_d     [STAGES];
    logic [1:0]            op_q    [STAGES];
    logic [1:0]            op_d    [STAGES];
    logic [TAG_WIDTH-1:0]  tag_q   [STAGES];
    logic [TAG_WIDTH-1:0]  tag_d   [STAGES];
    logic                  fill_q  [STAGES];
    logic                  fill_d  [STAGES];

    logic [STAGES-1:0]     stage_adv;
    logic [DATA_WIDTH-1:0] entry_data;
    logic                  entry_fill;

    // One log-level of the barrel shifter. Right shifts pull in the fill
    // bit at the top; rotate pulls in the bits that fell off the bottom.
    function automatic logic [DATA_WIDTH-1:0] shift_level(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            op,
        input logic                  fill,
        input int                    amt
    );
        logic [DATA_WIDTH-1:0] fill_mask;
        fill_mask = fill ? ~({DATA_WIDTH{1'b1}} >> amt) : '0;
        case (op)
            OP_SLL: return d << amt;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            OP_ROR: return (d >> amt) | (d << (DATA_WIDTH - amt));
`else
            // Data was zeroed at entry, so passing it through keeps it 0.
            OP_ROR: return d;
`endif
            default: return (d >> amt) | fill_mask;
        endcase
    endfunction

    // Apply every level that belongs to the given stage.
    function automatic logic [DATA_WIDTH-1:0] apply_levels(
        input logic [DATA_WIDTH-1:0] d,
        input logic [SHAMT_W-1:0]    b,
        input logic [1:0]            op,
        input logic                  fill,
        input int                    stage
    );
        logic [DATA_WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (((k * STAGES) / SHAMT_W) == stage && b[k]) begin
                r = shift_level(r, op, fill, 1 << k);
            end
        end
        return r;
    endfunction

    // Fill bit and operand as they enter stage 0. With rotate disabled the
    // undefined op is forced to zero here so it flows through as 0.
    always_comb begin
        entry_fill = (in_op == OP_SRA) ? in_a[DATA_WIDTH-1] : 1'b0;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        entry_data = in_a;
`else
        entry_data = (in_op == OP_ROR) ? '0 : in_a;
`endif
    end

    // Ready chain from the output back to the input: a stage may load when
    // it is empty or when its contents move on downstream in the same cycle.
    always_comb begin
        logic chain;
        chain     = out_ready;
        stage_adv = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain        = !valid_q[i] || chain;
            stage_adv[i] = chain;
        end
    end

    assign in_ready = stage_adv[0];

    // Next-state of every stage register. Payload is only reloaded when a
    // valid op moves in, so a draining stage keeps its last result.
    always_comb begin
        valid_d[0] = valid_q[0];
        data_d[0]  = data_q[0];
        b_d[0]     = b_q[0];
        op_d[0]    = op_q[0];
        tag_d[0]   = tag_q[0];
        fill_d[0]  = fill_q[0];
        if (stage_adv[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = apply_levels(entry_data, in_b, in_op, entry_fill, 0);
                b_d[0]    = in_b;
                op_d[0]   = in_op;
                tag_d[0]  = in_tag;
                fill_d[0] = entry_fill;
            end
        end

        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
            b_d[i]     = b_q[i];
            op_d[i]    = op_q[i];
            tag_d[i]   = tag_q[i];
            fill_d[i]  = fill_q[i];
            if (stage_adv[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = apply_levels(data_q[i-1], b_q[i-1], op_q[i-1],
                                             fill_q[i-1], i);
                    b_d[i]    = b_q[i-1];
                    op_d[i]   = op_q[i-1];
                    tag_d[i]  = tag_q[i-1];
                    fill_d[i] = fill_q[i-1];
                end
            end
        end
    end

    // Stage registers; reset empties the pipe and clears the payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                b_q[i]     <= '0;
                op_q[i]    <= '0;
                tag_q[i]   <= '0;
                fill_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= valid_d[i];
                data_q[i]  <= data_d[i];
                b_q[i]     <= b_d[i];
                op_q[i]    <= op_d[i];
                tag_q[i]   <= tag_d[i];
                fill_q[i]  <= fill_d[i];
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_result = data_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_shifter
//
// Directed bench for pipelined_shifter (DATA_WIDTH=32, STAGES=2, TAG_WIDTH=4).
// Expected results are queued when an op is accepted and compared, in order,
// when the shifter hands a result to the consumer.
// ---------------------------------------------------------------------------
module tb_pipelined_shifter;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 4;
    localparam int SW = 5;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] ROR = 2'b01;
    localparam logic [1:0] SRL = 2'b10;
    localparam logic [1:0] SRA = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [SW-1:0] in_b;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;

    typedef struct {
        logic [W-1:0]  result;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   pop_cyc[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    pipelined_shifter #(
        .DATA_WIDTH (W),
        .STAGES     (S),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference shifter used for the randomised back-to-back burst.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input int b,
                                           input logic [1:0] op);
        case (op)
            SLL:     return a << b;
            SRL:     return a >> b;
            SRA:     return W'($signed(a) >>> b);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            default: return (a >> b) | (a << (W - b));
`else
            default: return '0;
`endif
        endcase
    endfunction

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Offer one op and wait (bounded) until it is accepted; the expected
    // result is queued on the cycle the handshake completes.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [SW-1:0] b,
                                 input logic [1:0] op, input logic [TW-1:0] tag,
                                 input logic [W-1:0] exp);
        bit done = 1'b0;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                e.result = exp;
                e.tag    = tag;
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $error("[TB] FAIL accept_timeout observed=not_accepted expected=accepted tag=%0d", tag);
        end
    endtask

    // Wait (bounded) for all queued results to come out.
    task automatic drain();
        for (int n = 0; n < 30 && sb_q.size() != 0; n++) @(negedge clk);
        checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Output side: compare each accepted result against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                pop_cyc.push_back(cyc);
                checkOutput("result", 64'(out_result), 64'(e.result));
                checkOutput("tag", 64'(out_tag), 64'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]    op_tab [4];
        logic [W-1:0]  ra;
        logic [SW-1:0] rb;

        op_tab = '{SLL, SRL, SRA, ROR};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_result", 64'(out_result), 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: result appears exactly two cycles after accept
        applyStimulus(32'h0000_0001, 5'd31, SLL, 4'd3, 32'h8000_0000);
        @(negedge clk);
        checkOutput("latency_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("latency_cycle2_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Directed shifts, including b=0 and the SRA full-width case
        $display("[TB] directed shifts");
        applyStimulus(32'hF000_0000, 5'd4,  SRL, 4'd1, 32'h0F00_0000);
        applyStimulus(32'hF000_0000, 5'd4,  SRA, 4'd2, 32'hFF00_0000);
        applyStimulus(32'h8000_0000, 5'd31, SRA, 4'd4, 32'hFFFF_FFFF);
        applyStimulus(32'h7000_0000, 5'd4,  SRA, 4'd5, 32'h0700_0000);
        applyStimulus(32'h1234_5678, 5'd4,  SLL, 4'd6, 32'h2345_6780);
        applyStimulus(32'hA5A5_0F0F, 5'd0,  SLL, 4'd7, 32'hA5A5_0F0F);
        applyStimulus(32'hA5A5_0F0F, 5'd0,  SRL, 4'd8, 32'hA5A5_0F0F);
        applyStimulus(32'hA5A5_0F0F, 5'd0,  SRA, 4'd9, 32'hA5A5_0F0F);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        applyStimulus(32'hA5A5_0F0F, 5'd0,  ROR, 4'd10, 32'hA5A5_0F0F);
        applyStimulus(32'h0000_0001, 5'd1,  ROR, 4'd11, 32'h8000_0000);
        applyStimulus(32'h1234_5678, 5'd8,  ROR, 4'd12, 32'h7812_3456);
`else
        applyStimulus(32'hA5A5_0F0F, 5'd0,  ROR, 4'd10, 32'h0000_0000);
        applyStimulus(32'h0000_0001, 5'd1,  ROR, 4'd11, 32'h0000_0000);
        applyStimulus(32'h1234_5678, 5'd8,  ROR, 4'd12, 32'h0000_0000);
`endif
        drain();

        // Back-to-back burst of 8 ops: results must come out on 8 adjacent cycles
        $display("[TB] back-to-back burst");
        pop_cyc.delete();
        for (int t = 0; t < 8; t++) begin
            ra = $urandom;
            rb = 5'($urandom_range(0, 31));
            applyStimulus(ra, rb, op_tab[t % 4], 4'(t), model(ra, int'(rb), op_tab[t % 4]));
        end
        drain();
        checkOutput("b2b_count", 64'(pop_cyc.size()), 64'd8);
        if (pop_cyc.size() == 8) begin
            checkOutput("b2b_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);
        end

        // Backpressure: only two ops fit; the head result must hold still
        $display("[TB] backpressure");
        pop_cyc.delete();
        out_ready = 1'b0;
        applyStimulus(32'h0000_00FF, 5'd4, SLL, 4'd8, 32'h0000_0FF0);
        applyStimulus(32'hFFFF_0000, 5'd8, SRL, 4'd9, 32'h00FF_FF00);
        in_a     = 32'h8000_0001;
        in_b     = 5'd1;
        in_op    = SRA;
        in_tag   = 4'd10;
        in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid_held", 64'(out_valid), 64'd1);
            checkOutput("bp_result_held", 64'(out_result), 64'h0000_0FF0);
            checkOutput("bp_tag_held", 64'(out_tag), 64'd8);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(32'h8000_0001, 5'd1, SRA, 4'd10, 32'hC000_0000);
        applyStimulus(32'h0000_1234, 5'd8, SLL, 4'd11, 32'h0012_3400);
        drain();
        checkOutput("bp_all_emerged", 64'(pop_cyc.size()), 64'd4);

        // Reset with two ops in flight: pipe empties at once, nothing stale later
        $display("[TB] reset mid-flight");
        out_ready = 1'b0;
        applyStimulus(32'h1111_1111, 5'd1, SLL, 4'd12, 32'h2222_2222);
        applyStimulus(32'h2222_2222, 5'd1, SRL, 4'd13, 32'h1111_1111);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_async_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_async_out_result", 64'(out_result), 64'd0);
        checkOutput("rst_async_out_tag", 64'(out_tag), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("post_reset_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_0F00, 5'd8, SRL, 4'd14, 32'h0000_000F);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
